ula_seq_nbits: RTL and testbench
================================

Name: ula_seq_nbits

Overview:
- Sequencing front end for the external 8-bit 74181-style ALU (ula_8bits). Sits between a command producer and the ALU.
- Accepts a wide operation (N_SLICES x 8 bits) over a valid/ready command port and drives the ALU one 8-bit slice per cycle, LSB first, chaining the carry between slices.
- Assembles the wide result and returns it over a valid/ready response port.

Parameters:
N_SLICES, 2, number of 8-bit slices; data width W = 8*N_SLICES; legal range >= 1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command offered.
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
cmd_a  input  W  operand A.
cmd_b  input  W  operand B.
cmd_s  input  4  74181 function select.
cmd_m  input  1  1 = logic mode, 0 = arithmetic mode.
cmd_c_in  input  1  carry into slice 0, active-high (1 adds one).
alu_a  output  8  A slice to the ALU.
alu_b  output  8  B slice to the ALU.
alu_s  output  4  function select to the ALU.
alu_m  output  1  mode to the ALU.
alu_c_in  output  1  slice carry-in to the ALU.
alu_f  input  8  ALU result slice (combinational from alu_*).
alu_c_out  input  1  ALU carry-out, active-high.
alu_a_eq_b  input  1  ALU A=B flag.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer accepts result.
rsp_f  output  W  assembled result.
rsp_c_out  output  1  carry out of the top slice; 0 in logic mode.
rsp_a_eq_b  output  1  AND of alu_a_eq_b across all slices.

Behaviour:
- One clock, clk; rst_n asynchronous, active-low. All registers clear on rst_n low: state=IDLE, slice index=0, alu_*=0, rsp_valid=0, rsp_f=0, rsp_c_out=0, rsp_a_eq_b=0.
- cmd_ready is combinational: (state==IDLE) || (state==DONE && rsp_ready). No transfer is taken while rst_n is low.
- FSM states: IDLE, RUN, DONE.
- IDLE: on cmd handshake
  - latch A, B, s, m, c_in;
  - load alu_a/alu_b with slice 0, alu_s=cmd_s, alu_m=cmd_m, alu_c_in=cmd_c_in;
  - clear eq accumulator to 1; idx=0; go to RUN.
- RUN, every cycle:
  - capture alu_f into rsp_f[8*idx +: 8];
  - eq_acc &= alu_a_eq_b.
  - If idx < N_SLICES-1: idx++, drive the next slice, alu_c_in = alu_c_out (both modes).
  - Else: rsp_c_out = alu_c_out & ~m, rsp_a_eq_b = eq_acc & alu_a_eq_b, rsp_valid=1, go to DONE.
- DONE: hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp handshake with no new command: rsp_valid=0, go to IDLE.
  - On rsp handshake plus cmd handshake in the same cycle: perform the IDLE load and go straight to RUN (rsp_valid=0 next cycle).
- Latency: cmd handshake at edge T -> rsp_valid high after edge T+N_SLICES.
  - Throughput with rsp_ready tied high: one command per N_SLICES+1 cycles.
- alu_* are registered, so the ALU sees stable inputs for a full cycle; result is sampled at the end of that cycle. No combinational path from alu_f to alu_*.
- Slice width arithmetic is fixed at 8; carry chaining uses the ALU's active-high carry convention only.
- N_SLICES=1: RUN lasts one cycle, no chaining.
- Reset mid-operation (RUN or DONE): state returns to IDLE immediately. The in-flight command and any unconsumed result are dropped; no response is emitted.
- rsp_f bits of slices not yet captured are don't-care until rsp_valid. Benches check rsp_f only when rsp_valid=1.

Decomposition:
- Package ula_pkg:
  - SLICE_W=8;
  - typedef enum state_e {IDLE, RUN, DONE};
  - select constants: S_A_PLUS_CIN=4'b0000, S_A_PLUS_B=4'b1001, S_XOR=4'b0110 (m=1), S_A_LOGIC=4'b1111 (m=1).
- No sub-module inside the block. The ALU stays external; a bench-level top ula_seq_top instantiates ula_seq_nbits plus ula_8bits.

Test Plan (N_SLICES=2, through ula_seq_top):
- Carry crosses slices: a=0x00FF, b=0x0000, s=0000, m=0, c_in=1 -> rsp_f=0x0100, rsp_c_out=0, rsp_valid exactly 2 cycles after handshake.
- Top carry out: a=0xFFFF, b=0x0001, s=1001, m=0, c_in=0 -> rsp_f=0x0000, rsp_c_out=1.
- Logic mode masks carry: a=0x0F0F, b=0x00FF, s=0110, m=1 -> rsp_f=0x0FF0, rsp_c_out=0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_f/rsp_c_out stable, cmd_ready=0 throughout; release -> rsp_valid drops next cycle.
- Back-to-back: rsp_ready=1, cmd_valid held with two commands (0x0001+0x0001 then 0x00FF+Cin) -> cmd_ready high in DONE cycle; results 0x0002 then 0x0100, 3 cycles apart.
- Reset in RUN: drop rst_n while idx=1 -> rsp_valid=0 and alu_*=0 immediately; after release cmd_ready=1 and no response appears for the aborted command.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared types and constants for the sliced ALU sequencer.
// Slice width, FSM states and common 74181 select codes.
package ula_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] S_A_PLUS_CIN = 4'b0000;
  localparam logic [3:0] S_A_PLUS_B   = 4'b1001;
  localparam logic [3:0] S_XOR        = 4'b0110;
  localparam logic [3:0] S_A_LOGIC    = 4'b1111;

endpackage

// File: rtl/ula_seq_nbits.sv
// Drives an external 8-bit 74181-style ALU one slice per cycle, LSB first.
// Ports: cmd_* (valid/ready request), alu_* (ALU slice I/F), rsp_* (result).
module ula_seq_nbits
  import ula_pkg::*;
#(
  parameter  int N_SLICES = 2,
  localparam int W        = SLICE_W * N_SLICES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [W-1:0]       cmd_a,
  input  logic [W-1:0]       cmd_b,
  input  logic [3:0]         cmd_s,
  input  logic               cmd_m,
  input  logic               cmd_c_in,
  output logic [SLICE_W-1:0] alu_a,
  output logic [SLICE_W-1:0] alu_b,
  output logic [3:0]         alu_s,
  output logic               alu_m,
  output logic               alu_c_in,
  input  logic [SLICE_W-1:0] alu_f,
  input  logic               alu_c_out,
  input  logic               alu_a_eq_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_f,
  output logic               rsp_c_out,
  output logic               rsp_a_eq_b
);

  localparam int IW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

  state_e        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          m_q;
  logic          eq_acc;
  logic          last;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;

  assign cmd_ready = (state == IDLE) ||
                     (state == DONE && rsp_ready);

  assign last = !(int'(idx) < N_SLICES - 1);

  // Operands shifted so the next slice sits in the low byte.
  always_comb begin
    a_sh = a_q >> (SLICE_W * (int'(idx) + 1));
    b_sh = b_q >> (SLICE_W * (int'(idx) + 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= 1'b0;
      eq_acc     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      alu_m      <= 1'b0;
      alu_c_in   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_f      <= '0;
      rsp_c_out  <= 1'b0;
      rsp_a_eq_b <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          rsp_f[SLICE_W*idx +: SLICE_W] <= alu_f;
          eq_acc <= eq_acc & alu_a_eq_b;
          if (!last) begin
            idx      <= idx + IW'(1);
            alu_a    <= a_sh[SLICE_W-1:0];
            alu_b    <= b_sh[SLICE_W-1:0];
            alu_c_in <= alu_c_out;
          end else begin
            rsp_c_out  <= alu_c_out & ~m_q;
            rsp_a_eq_b <= eq_acc & alu_a_eq_b;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase
      // Load shares IDLE and the DONE-with-handshake path.
      if (cmd_valid && cmd_ready) begin
        a_q      <= cmd_a;
        b_q      <= cmd_b;
        m_q      <= cmd_m;
        alu_a    <= cmd_a[SLICE_W-1:0];
        alu_b    <= cmd_b[SLICE_W-1:0];
        alu_s    <= cmd_s;
        alu_m    <= cmd_m;
        alu_c_in <= cmd_c_in;
        eq_acc   <= 1'b1;
        idx      <= '0;
        state    <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_ula_seq_nbits.sv
// Self-checking bench for ula_seq_nbits with a behavioural 8-bit ALU.
// Directed plan cases followed by random commands against a wide model.
module tb_ula_seq_nbits;
  import ula_pkg::*;

  localparam int N = 2;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [3:0]   cmd_s = '0;
  logic         cmd_m = 1'b0;
  logic         cmd_c_in = 1'b0;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_c_in;
  logic [7:0]   alu_f;
  logic         alu_c_out;
  logic         alu_a_eq_b;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_f;
  logic         rsp_c_out;
  logic         rsp_a_eq_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ula_seq_nbits #(.N_SLICES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s),
    .cmd_m(cmd_m), .cmd_c_in(cmd_c_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_m(alu_m), .alu_c_in(alu_c_in),
    .alu_f(alu_f), .alu_c_out(alu_c_out),
    .alu_a_eq_b(alu_a_eq_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_c_out(rsp_c_out),
    .rsp_a_eq_b(rsp_a_eq_b)
  );

  // Stand-in 8-bit ALU: only the four select codes used here.
  // Logic mode reports carry 1 so the sequencer's masking is visible.
  always_comb begin
    logic [8:0] sum;
    sum = '0;
    if (!alu_m) begin
      if (alu_s == S_A_PLUS_B)
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};
      else
        sum = {1'b0, alu_a} + {8'd0, alu_c_in};
    end else begin
      if (alu_s == S_XOR) sum = {1'b1, alu_a ^ alu_b};
      else                sum = {1'b1, alu_a};
    end
    alu_f      = sum[7:0];
    alu_c_out  = sum[8];
    alu_a_eq_b = (alu_a == alu_b);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-width reference: plain arithmetic on the full operands.
  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic m,
                        input logic cin, output logic [W-1:0] f,
                        output logic c, output logic eq);
    logic [W:0] full;
    if (!m) begin
      full = {1'b0, a} + {W'(0), cin};
      if (s == S_A_PLUS_B) full = full + {1'b0, b};
      f = full[W-1:0];
      c = full[W];
    end else begin
      f = (s == S_XOR) ? (a ^ b) : a;
      c = 1'b0;
    end
    eq = (a == b);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] s, input logic m,
                       input logic cin);
    cmd_a = a; cmd_b = b; cmd_s = s; cmd_m = m; cmd_c_in = cin;
    cmd_valid = 1'b1;
  endtask

  // One command from IDLE with rsp_ready high; checks latency and result.
  task automatic run_cmd(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] s,
                         input logic m, input logic cin);
    logic [W-1:0] ef;
    logic ec, eq;
    int cyc;
    ref_op(a, b, s, m, cin, ef, ec, eq);
    @(negedge clk);
    drive(a, b, s, m, cin);
    check({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(N));
    check({tag, "_f"}, 32'(rsp_f), 32'(ef));
    check({tag, "_c"}, 32'(rsp_c_out), 32'(ec));
    check({tag, "_eq"}, 32'(rsp_a_eq_b), 32'(eq));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] hold_f;
    logic hold_c;
    logic seen;

    #12;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_f", 32'(rsp_f), 32'd0);
    check("rst_c", 32'(rsp_c_out), 32'd0);
    check("rst_eq", 32'(rsp_a_eq_b), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_s, alu_m, alu_c_in}), 32'd0);
    check("rst_cmd_rdy", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd("carry_x", 16'h00FF, 16'h0000, S_A_PLUS_CIN, 1'b0, 1'b1);
    run_cmd("top_c", 16'hFFFF, 16'h0001, S_A_PLUS_B, 1'b0, 1'b0);
    run_cmd("logic", 16'h0F0F, 16'h00FF, S_XOR, 1'b1, 1'b0);
    run_cmd("eq", 16'h1234, 16'h1234, S_A_LOGIC, 1'b1, 1'b1);

    // Backpressure: result held, no new command accepted.
    rsp_ready = 1'b0;
    @(negedge clk);
    drive(16'h7F80, 16'h0181, S_A_PLUS_B, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(16'h1111, 16'h2222, S_A_PLUS_B, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_valid", 32'(rsp_valid), 32'd1);
    check("bp_f", 32'(rsp_f), 32'h8102);
    hold_f = rsp_f;
    hold_c = rsp_c_out;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_f", 32'(rsp_f), 32'(hold_f));
      check("bp_hold_c", 32'(rsp_c_out), 32'(hold_c));
      check("bp_cmd_rdy", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 32'(rsp_valid), 32'd0);

    // Back-to-back: second command accepted in the DONE cycle.
    @(negedge clk);
    drive(16'h0001, 16'h0001, S_A_PLUS_B, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'h00FF, 16'h0000, S_A_PLUS_CIN, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("b2b_busy", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("b2b_v1", 32'(rsp_valid), 32'd1);
    check("b2b_f1", 32'(rsp_f), 32'h0002);
    check("b2b_rdy", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_gap1", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("b2b_gap2", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("b2b_v2", 32'(rsp_valid), 32'd1);
    check("b2b_f2", 32'(rsp_f), 32'h0100);
    @(posedge clk); #1;

    // Reset while the second slice is on the ALU.
    @(negedge clk);
    drive(16'h00FF, 16'h0101, S_A_PLUS_B, 1'b0, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rr_hi_slice", 32'(alu_a), 32'h00);
    check("rr_hi_b", 32'(alu_b), 32'h01);
    rst_n = 1'b0;
    #1;
    check("rr_valid", 32'(rsp_valid), 32'd0);
    check("rr_alu", 32'({alu_a, alu_b, alu_s, alu_m, alu_c_in}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rr_cmd_rdy", 32'(cmd_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("rr_no_rsp", 32'(seen), 32'd0);

    // Random commands over the supported select codes.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      logic [3:0] s;
      logic m;
      int k;
      a = W'($urandom);
      b = (i % 4 == 0) ? a : W'($urandom);
      k = $urandom_range(0, 3);
      case (k)
        0: begin s = S_A_PLUS_CIN; m = 1'b0; end
        1: begin s = S_A_PLUS_B;   m = 1'b0; end
        2: begin s = S_XOR;        m = 1'b1; end
        default: begin s = S_A_LOGIC; m = 1'b1; end
      endcase
      run_cmd("rnd", a, b, s, m, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
